// File: rtl/axi_burst_pkg.sv
// ============================================================================
// Module  : axi_burst_pkg
// Brief   : Shared widths, FSM state codes and bus field positions for the
//           burst master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_burst_pkg;

    localparam int ADDR_W  = 8;
    localparam int LEN_W   = 4;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_AR   = 3'd1;
    localparam logic [STATE_W-1:0] ST_R    = 3'd2;
    localparam logic [STATE_W-1:0] ST_AW   = 3'd3;
    localparam logic [STATE_W-1:0] ST_W    = 3'd4;
    localparam logic [STATE_W-1:0] ST_B    = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd6;

    // Read request {addr, len, id}
    localparam int IN_W        = ADDR_W + LEN_W + ID_W;
    localparam int IN_ID_LSB   = 0;
    localparam int IN_LEN_LSB  = ID_W;
    localparam int IN_ADDR_LSB = ID_W + LEN_W;

    // Write request {addr, id}
    localparam int AWIN_W        = ADDR_W + ID_W;
    localparam int AWIN_ID_LSB   = 0;
    localparam int AWIN_ADDR_LSB = ID_W;

    // Read beat {data, err}
    localparam int OUT_W        = DATA_W + 1;
    localparam int OUT_ERR_BIT  = 0;
    localparam int OUT_DATA_LSB = 1;

    // Write response {err, id}
    localparam int BRESP_W       = ID_W + 1;
    localparam int BRESP_ID_LSB  = 0;
    localparam int BRESP_ERR_BIT = ID_W;

endpackage

`default_nettype wire

// File: rtl/axi_burst_beat_ctr.sv
// ============================================================================
// Module  : axi_burst_beat_ctr
// Brief   : Burst beat counter with a "next beat is the last" compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_beat_ctr
    import axi_burst_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_last
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Extra bit keeps count+1 from wrapping before the compare.
    assign o_last = (({1'b0, count_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, i_len});

endmodule

`default_nettype wire

// File: rtl/axi_burst_master.sv
// ============================================================================
// Module  : axi_burst_master
// Brief   : Single-outstanding burst master for the burst memory slave.
//           Optional watchdog enabled by defining MASTER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_master
    import axi_burst_pkg::*;
`ifdef MASTER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [ID_W-1:0]    cmd_id,
    input  logic               wr_data_valid,
    output logic               wr_data_ready,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               rd_data_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_err,
    output logic               rd_last,
    output logic               done_valid,
    output logic [ID_W-1:0]    done_id,
    output logic               done_err,
    output logic               ARVALID,
    output logic [IN_W-1:0]    IN,
    input  logic               ARREADY,
    input  logic               RVALID,
    output logic               RREADY,
    input  logic [OUT_W-1:0]   OUT,
    input  logic               RLAST,
    output logic               AWVALID,
    output logic [AWIN_W-1:0]  AWIN,
    input  logic               AWREADY,
    output logic               WVALID,
    output logic [DATA_W-1:0]  WDATA,
    output logic               WLAST,
    input  logic               WREADY,
    input  logic               BVALID,
    output logic               BREADY,
    input  logic [BRESP_W-1:0] BRESP
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               err_q, err_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               bready_q, bready_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_err_q, rd_err_d;
    logic               rd_last_q, rd_last_d;
    logic               done_valid_q, done_valid_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic               done_err_q, done_err_d;

    logic w_accept;
    logic w_in_w;
    logic w_ctr_inc;
    logic w_ctr_last;
    logic w_rd_final;
    logic w_timeout;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_in_w    = (state_q == ST_W);

    assign WVALID        = w_in_w && wr_data_valid;
    assign WDATA         = w_in_w ? wr_data : '0;
    assign WLAST         = w_in_w && w_ctr_last;
    assign wr_data_ready = w_in_w && WREADY;

    axi_burst_beat_ctr u_beat_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_inc  (w_ctr_inc),
        .i_len  (len_q),
        .o_last (w_ctr_last)
    );

`ifdef MASTER_TIMEOUT_EN
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WDOG_W-1:0] wdog_q, wdog_d;
    logic                w_handshake;
    logic                w_busy;

    assign w_handshake = (arvalid_q && ARREADY) || (rready_q && RVALID) ||
                         (awvalid_q && AWREADY) || (WVALID && WREADY) ||
                         (bready_q && BVALID);
    assign w_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign w_timeout   = w_busy && (wdog_q == c_WDOG_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wdog_d = wdog_q + 1'b1;
        if (!w_busy || w_handshake || (state_d != state_q)) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        err_d        = err_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        bready_d     = bready_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_err_d     = rd_err_q;
        rd_last_d    = 1'b0;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        done_err_d   = done_err_q;
        w_ctr_inc    = 1'b0;
        w_rd_final   = RLAST || w_ctr_last;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    id_d   = cmd_id;
                    err_d  = 1'b0;
                    if (cmd_len == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cmd_write) begin
                        awvalid_d = 1'b1;
                        state_d   = ST_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (RVALID && rready_q) begin
                    w_ctr_inc  = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = OUT[OUT_DATA_LSB +: DATA_W];
                    rd_err_d   = OUT[OUT_ERR_BIT];
                    rd_last_d  = w_rd_final;
                    err_d      = err_q || OUT[OUT_ERR_BIT];
                    if (w_rd_final) begin
                        // Slave and master disagreeing on burst end is an error.
                        err_d    = err_q || OUT[OUT_ERR_BIT] || (RLAST ^ w_ctr_last);
                        rready_d = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_AW: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (WVALID && WREADY) begin
                    w_ctr_inc = 1'b1;
                    if (w_ctr_last) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end
                end
            end
            ST_B: begin
                if (BVALID) begin
                    bready_d = 1'b0;
                    err_d    = BRESP[BRESP_ERR_BIT] ||
                               (BRESP[BRESP_ID_LSB +: ID_W] != id_q);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid_d = 1'b1;
                done_id_d    = id_q;
                done_err_d   = err_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_timeout) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            awvalid_d = 1'b0;
            bready_d  = 1'b0;
            w_ctr_inc = 1'b0;
            err_d     = 1'b1;
            state_d   = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_err_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            err_q        <= err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            bready_q     <= bready_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_err_q     <= rd_err_d;
            rd_last_q    <= rd_last_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_err_q   <= done_err_d;
        end
    end

    always_comb begin
        IN                           = '0;
        IN[IN_ADDR_LSB +: ADDR_W]    = addr_q;
        IN[IN_LEN_LSB  +: LEN_W]     = len_q;
        IN[IN_ID_LSB   +: ID_W]      = id_q;
        AWIN                         = '0;
        AWIN[AWIN_ADDR_LSB +: ADDR_W] = addr_q;
        AWIN[AWIN_ID_LSB   +: ID_W]   = id_q;
    end

    assign ARVALID       = arvalid_q;
    assign RREADY        = rready_q;
    assign AWVALID       = awvalid_q;
    assign BREADY        = bready_q;
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_err        = rd_err_q;
    assign rd_last       = rd_last_q;
    assign done_valid    = done_valid_q;
    assign done_id       = done_id_q;
    assign done_err      = done_err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_master.sv
// ============================================================================
// Module  : tb_axi_burst_master
// Brief   : Scoreboard bench for axi_burst_master with a behavioural slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len, cmd_id;
    logic        wr_data_valid, wr_data_ready;
    logic [7:0]  wr_data;
    logic        rd_data_valid, rd_err, rd_last;
    logic [7:0]  rd_data;
    logic        done_valid, done_err;
    logic [3:0]  done_id;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [15:0] IN;
    logic [8:0]  OUT;
    logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
    logic [11:0] AWIN;
    logic [7:0]  WDATA;
    logic [4:0]  BRESP;

    logic [7:0]  mem [256];
    logic [7:0]  wbuf [16];
    logic [9:0]  rd_exp [$];
    logic [8:0]  wr_exp [$];
    logic [4:0]  done_exp [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    bit          saw_addr = 1'b0;
    bit          stall_ar = 1'b0;

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_last(rd_last),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .ARVALID(ARVALID), .IN(IN), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .OUT(OUT), .RLAST(RLAST),
        .AWVALID(AWVALID), .AWIN(AWIN), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s unexpected output 0x%0h with nothing pending", name, act);
    endtask

    // Scoreboard monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (ARVALID || AWVALID) saw_addr = 1'b1;
            if (rd_data_valid) begin
                rd_cnt++;
                if (rd_exp.size() == 0) unexpected("rd_beat", 32'({rd_data, rd_err, rd_last}));
                else check("rd_beat", 32'({rd_data, rd_err, rd_last}), 32'(rd_exp.pop_front()));
            end
            if (WVALID && WREADY) begin
                if (wr_exp.size() == 0) unexpected("wr_beat", 32'({WDATA, WLAST}));
                else check("wr_beat", 32'({WDATA, WLAST}), 32'(wr_exp.pop_front()));
            end
            if (done_valid) begin
                done_cnt++;
                if (done_exp.size() == 0) unexpected("done", 32'({done_id, done_err}));
                else check("done", 32'({done_id, done_err}), 32'(done_exp.pop_front()));
            end
        end
    end

    // Behavioural burst memory slave; out-of-range beats flag err.
    initial begin : slave
        logic [7:0] s_addr;
        logic [3:0] s_len;
        logic [3:0] s_id;
        logic [8:0] a;
        logic [7:0] d;
        logic       hs, last, s_err;
        int         i, g;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        ARREADY = 0; RVALID = 0; OUT = '0; RLAST = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
        forever begin
            tick();
            if (rst) begin
                ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
            end else if (ARVALID && !stall_ar) begin
                s_addr = IN[15:8]; s_len = IN[7:4]; s_id = IN[3:0];
                ARREADY = 1;
                tick();
                ARREADY = 0;
                i = 0; g = 0;
                while (i < int'(s_len) && !rst && g < 100) begin
                    if (RREADY && !ARVALID) begin
                        a = {1'b0, s_addr} + 9'(i);
                        RVALID = 1;
                        RLAST = (i == int'(s_len) - 1);
                        OUT = a[8] ? 9'h001 : {mem[a[7:0]], 1'b0};
                        i++;
                    end else begin
                        RVALID = 0;
                    end
                    tick();
                    g++;
                end
                RVALID = 0; RLAST = 0;
            end else if (AWVALID) begin
                s_addr = AWIN[11:4]; s_id = AWIN[3:0];
                AWREADY = 1;
                tick();
                AWREADY = 0; WREADY = 1;
                i = 0; g = 0; last = 0; s_err = 0;
                while (!last && !rst && g < 100) begin
                    @(negedge clk);
                    hs = WVALID && WREADY;
                    d = WDATA;
                    if (hs) last = WLAST;
                    tick();
                    g++;
                    if (hs) begin
                        a = {1'b0, s_addr} + 9'(i);
                        if (a[8]) s_err = 1; else mem[a[7:0]] = d;
                        i++;
                    end
                end
                WREADY = 0;
                if (!rst && last) begin
                    BVALID = 1; BRESP = {s_err, s_id};
                    hs = 0; g = 0;
                    while (!hs && !rst && g < 100) begin
                        @(negedge clk);
                        hs = BREADY;
                        tick();
                        g++;
                    end
                    BVALID = 0;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l, input logic [3:0] id);
        int   g = 0;
        logic hs = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
        while (!hs && g < 50) begin
            @(negedge clk);
            hs = cmd_ready;
            tick();
            g++;
        end
        cmd_valid = 0;
        if (!hs) check("cmd_accept_timeout", 32'(hs), 32'(1));
    endtask

    task automatic send_wr(input int n, input bit gap);
        int   j = 0;
        int   g = 0;
        bit   ph = 1'b1;
        logic hs;
        while (j < n && g < 200) begin
            wr_data = wbuf[j];
            wr_data_valid = gap ? ph : 1'b1;
            @(negedge clk);
            hs = wr_data_valid && wr_data_ready;
            tick();
            ph = ~ph;
            g++;
            if (hs) j++;
        end
        wr_data_valid = 0;
        if (j < n) check("wr_data_timeout", 32'(j), 32'(n));
    endtask

    task automatic wait_done(input int start, input string name, output int cycles);
        cycles = 0;
        while (done_cnt == start && cycles < 400) begin
            tick();
            cycles++;
        end
        if (done_cnt == start) check(name, 32'(done_cnt), 32'(start + 1));
    endtask

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : host
        int s, cyc, g;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_data_valid = 0; wr_data = '0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_outputs", 32'({cmd_ready, ARVALID, RREADY, AWVALID, WVALID, BREADY,
                                    rd_data_valid, done_valid, IN}), 32'(0));
        check("reset_awin", 32'(AWIN), 32'(0));
        tick();
        rst = 0;
        tick();

        // Write A1..A4 at 0x10
        wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
        wr_exp.push_back({8'hA1, 1'b0}); wr_exp.push_back({8'hA2, 1'b0});
        wr_exp.push_back({8'hA3, 1'b0}); wr_exp.push_back({8'hA4, 1'b1});
        done_exp.push_back({4'd3, 1'b0});
        s = done_cnt;
        issue(1'b1, 8'h10, 4'd4, 4'd3);
        send_wr(4, 1'b0);
        wait_done(s, "wr1_done_timeout", cyc);

        // Read back the same range
        rd_exp.push_back({8'hA1, 1'b0, 1'b0}); rd_exp.push_back({8'hA2, 1'b0, 1'b0});
        rd_exp.push_back({8'hA3, 1'b0, 1'b0}); rd_exp.push_back({8'hA4, 1'b0, 1'b1});
        done_exp.push_back({4'd3, 1'b0});
        s = done_cnt;
        issue(1'b0, 8'h10, 4'd4, 4'd3);
        wait_done(s, "rd1_done_timeout", cyc);

        // Read crossing the top of memory
        rd_exp.push_back({8'hFE, 1'b0, 1'b0}); rd_exp.push_back({8'hFF, 1'b0, 1'b0});
        rd_exp.push_back({8'h00, 1'b1, 1'b0}); rd_exp.push_back({8'h00, 1'b1, 1'b1});
        done_exp.push_back({4'd7, 1'b1});
        s = done_cnt;
        issue(1'b0, 8'hFE, 4'd4, 4'd7);
        wait_done(s, "rd_wrap_done_timeout", cyc);

        // Zero-length command
        tick();
        saw_addr = 1'b0;
        done_exp.push_back({4'd9, 1'b1});
        issue(1'b0, 8'h30, 4'd0, 4'd9);
        @(negedge clk);
        check("len0_done_early", 32'(done_valid), 32'(0));
        tick();
        @(negedge clk);
        check("len0_done_at_2", 32'({done_valid, done_id, done_err}), 32'({1'b1, 4'd9, 1'b1}));
        tick();
        tick();
        check("len0_no_addr_valid", 32'(saw_addr), 32'(0));

        // Gapped write, len 3
        wbuf[0] = 8'h5A; wbuf[1] = 8'h5B; wbuf[2] = 8'h5C;
        wr_exp.push_back({8'h5A, 1'b0}); wr_exp.push_back({8'h5B, 1'b0});
        wr_exp.push_back({8'h5C, 1'b1});
        done_exp.push_back({4'hC, 1'b0});
        s = done_cnt;
        issue(1'b1, 8'h50, 4'd3, 4'hC);
        send_wr(3, 1'b1);
        wait_done(s, "wr_gap_done_timeout", cyc);

        // Reset during a len-8 read
        for (int k = 0; k < 8; k++) rd_exp.push_back({8'(8'h40 + k), 1'b0, (k == 7)});
        s = done_cnt;
        g = rd_cnt;
        issue(1'b0, 8'h40, 4'd8, 4'd4);
        cyc = 0;
        while (rd_cnt < g + 3 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("rst_beats_before", 32'(rd_cnt >= g + 3), 32'(1));
        rst = 1;
        tick();
        rd_exp.delete();
        @(negedge clk);
        check("rst_bus_zero", 32'({cmd_ready, ARVALID, RREADY, AWVALID, WVALID, BREADY,
                                   rd_data_valid, done_valid}), 32'(0));
        tick();
        rst = 0;
        repeat (4) tick();
        check("rst_no_done", 32'(done_cnt), 32'(s));

        // Normal read after reset
        rd_exp.push_back({8'h20, 1'b0, 1'b0}); rd_exp.push_back({8'h21, 1'b0, 1'b1});
        done_exp.push_back({4'd5, 1'b0});
        s = done_cnt;
        issue(1'b0, 8'h20, 4'd2, 4'd5);
        wait_done(s, "rd_after_rst_timeout", cyc);

`ifdef MASTER_TIMEOUT_EN
        tick();
        stall_ar = 1'b1;
        done_exp.push_back({4'd6, 1'b1});
        s = done_cnt;
        issue(1'b0, 8'h00, 4'd2, 4'd6);
        wait_done(s, "timeout_done_timeout", cyc);
        check("timeout_latency", 32'(cyc >= 250 && cyc <= 262), 32'(1));
        check("timeout_arvalid", 32'(ARVALID), 32'(0));
        stall_ar = 1'b0;
`endif

        repeat (3) tick();
        check("rd_exp_drained", 32'(rd_exp.size()), 32'(0));
        check("wr_exp_drained", 32'(wr_exp.size()), 32'(0));
        check("done_exp_drained", 32'(done_exp.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Bus master that sits directly upstream of the team's burst memory slave.
- Takes one host command at a time (read or write burst) and drives the slave's AR/R or AW/W/B channels.
- Streams read beats back to the host and pulls write beats from the host.
- Reports one completion per command with an error flag.

Parameters:
- ADDR_W, 8, byte address width (fixed by slave memory of 256 bytes).
- LEN_W, 4, burst length field width.
- ID_W, 4, transaction ID width.
- DATA_W, 8, data beat width.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with MASTER_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  master idle, command accepted on cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  8  start byte address.
- cmd_len  in  4  beat count, 1..15.
- cmd_id  in  4  transaction ID.
- wr_data_valid  in  1  host write beat valid.
- wr_data_ready  out  1  host write beat taken.
- wr_data  in  8  host write beat.
- rd_data_valid  out  1  one-cycle pulse per read beat.
- rd_data  out  8  read beat.
- rd_err  out  1  slave error bit of this beat.
- rd_last  out  1  final read beat.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  4  ID of completed command.
- done_err  out  1  command failed.
- ARVALID  out  1  read address valid.
- IN  out  16  read request {addr[15:8], len[7:4], id[3:0]}.
- ARREADY  in  1  read address accepted.
- RVALID  in  1  read beat valid.
- RREADY  out  1  master accepting read beats.
- OUT  in  9  read beat {data[8:1], err[0]}.
- RLAST  in  1  last read beat.
- AWVALID  out  1  write address valid.
- AWIN  out  12  write request {addr[11:4], id[3:0]}.
- AWREADY  in  1  write address accepted.
- WVALID  out  1  write beat valid.
- WDATA  out  8  write beat.
- WLAST  out  1  final write beat.
- WREADY  in  1  slave accepting write beats.
- BVALID  in  1  write response valid.
- BREADY  out  1  master accepting response.
- BRESP  in  5  {err[4], id[3:0]}.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all registered outputs 0, beat counter 0, latched cmd fields 0. cmd_ready is 0 while rst=1.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_len==0: go to DONE with done_err=1. No bus activity.
  - Otherwise latch addr/len/id and go to AR (read) or AW (write).
- AR:
  - ARVALID=1 and IN held stable until ARREADY=1.
  - The next cycle ARVALID=0, RREADY=1, state goes to R. ARVALID must drop before RREADY is used (the slave requires !ARVALID&&RREADY).
- R:
  - Each RVALID&&RREADY cycle registers rd_data=OUT[8:1] and rd_err=OUT[0], pulses rd_data_valid the following cycle, and increments the count.
  - rd_last=1 on the beat with RLAST or count+1==len.
  - Exit to DONE on that beat; RREADY drops.
  - done_err = OR of beat errs, OR (RLAST xor count+1==len).
- AW: AWVALID=1, AWIN={addr,id} until AWREADY; the next cycle AWVALID=0 and state goes to W.
- W:
  - WVALID=wr_data_valid, WDATA=wr_data, wr_data_ready=WREADY (combinational pass-through while in W).
  - WLAST=1 when count+1==len.
  - Beat counted on WVALID&&WREADY; after the len-th beat, WVALID=WLAST=0 and state goes to B.
- B:
  - BREADY=1 until BVALID, then capture BRESP.
  - done_err = BRESP[4] OR (BRESP[3:0]!=id). Go to DONE.
- DONE: done_valid=1 for exactly one cycle with done_id=id; return to IDLE. Back-to-back commands have 1 idle cycle minimum.
- Address wrap: the master never splits bursts. Beats beyond address 255 are reported via the slave error bits.
- Reset mid-burst: aborts immediately with no done pulse; all bus valids and readies are 0 on the cycle after reset.

Optional Feature:
- MASTER_TIMEOUT_EN defined:
  - Per-state watchdog counter, cleared on every handshake/state change.
  - Reaching TIMEOUT_CYCLES in AR/R/AW/W/B forces all bus outputs to 0 and goes to DONE with done_err=1.
- Undefined: no counter; the master waits indefinitely.

Decomposition:
- Shared package axi_burst_pkg holds:
  - state enum;
  - width constants ADDR_W/LEN_W/ID_W/DATA_W;
  - field slice positions for IN, AWIN, OUT, BRESP.
- One natural sub-module: axi_burst_beat_ctr (beat counter plus last-beat compare), instanced once and shared by R and W.

Test Plan:
- Write addr 0x10, len 4, id 3, data A1..A4, then read the same range -> rd_data A1,A2,A3,A4, rd_last on 4th; both done_err=0, done_id=3.
- Read addr 0xFE, len 4 -> beats 3,4 have rd_err=1, done_err=1.
- cmd_len=0 -> done_valid 2 cycles after accept with done_err=1; ARVALID/AWVALID never asserted.
- Write with wr_data_valid gapped every other cycle, len 3 -> exactly 3 beats written, WLAST only on the 3rd, BRESP id matches -> done_err=0.
- rst pulsed during R phase of a len-8 read -> next cycle all outputs 0, no done_valid; the following read completes normally.
- With MASTER_TIMEOUT_EN, slave ARREADY held low -> done_err=1 after 255 cycles, ARVALID=0.
